// File: rtl/dds_multi_sweep.sv
// dds_multi_sweep: multi-channel swept-frequency DDS with parabolic cosine output
module dds_multi_sweep #(
  parameter int NCH = 2,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  localparam int LCH_W = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_sync,
  input  logic               i_load_en,
  input  logic [LCH_W-1:0]   i_load_ch,
  input  logic [1:0]         i_load_sel,
  input  logic [ACC_W-1:0]   i_load_data,
  output logic [NCH*OUT_W-1:0] o_cos_out,
  output logic               o_out_valid,
  output logic [NCH-1:0]     o_sweep_wrap,
  output logic [NCH*OUT_W-1:0] o_io_oeb
);
  localparam int PW = 2 * OUT_W;
  localparam logic [OUT_W-1:0] HALF = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] QUARTER = {2'b01, {(OUT_W-2){1'b0}}};
  localparam logic [OUT_W-1:0] MAXV = HALF - 1'b1;
  logic [ACC_W-1:0] r_acc [NCH];
  logic [ACC_W-1:0] r_freq_cur [NCH];
  logic [ACC_W-1:0] r_freq_start [NCH];
  logic [ACC_W-1:0] r_poff [NCH];
  logic [ACC_W-1:0] r_step [NCH];
  logic [ACC_W-1:0] r_limit [NCH];
  logic [OUT_W-1:0] r_v [NCH];
  logic [OUT_W-1:0] r_cos [NCH];
  logic [NCH-1:0]   r_wrap;
  logic [1:0]       r_en_d;
  logic signed [ACC_W+1:0] w_nxt [NCH];
  logic [OUT_W-1:0] w_v [NCH];
  logic [OUT_W-1:0] w_rem [NCH];
  logic [OUT_W-1:0] w_sh [NCH];
  logic [OUT_W-1:0] w_mag [NCH];
  logic [OUT_W-1:0] w_cos [NCH];
  logic [NCH-1:0]   w_sel, w_ld_freq, w_sweep, w_cross;
  // Per-channel sweep step, load decode, phase-to-index and parabolic magnitude
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_nxt[k] = $signed({2'b00, r_freq_cur[k]}) + $signed({{2{r_step[k][ACC_W-1]}}, r_step[k]});
      w_cross[k] = r_step[k][ACC_W-1] ? (w_nxt[k] < $signed({2'b00, r_limit[k]})) : (w_nxt[k] > $signed({2'b00, r_limit[k]}));
      w_sel[k] = i_load_en && (i_load_ch == LCH_W'(k));
      w_ld_freq[k] = w_sel[k] && (i_load_sel == 2'd0);
      w_sweep[k] = i_enable && (r_step[k] != '0) && !w_ld_freq[k];
      w_v[k] = OUT_W'((r_acc[k] + r_poff[k]) >> (ACC_W - OUT_W)) + QUARTER;
      w_rem[k] = HALF - {1'b0, r_v[k][OUT_W-2:0]};
      w_sh[k] = OUT_W'((PW'(r_v[k][OUT_W-2:0]) * PW'(w_rem[k])) >> (OUT_W - 3));
      w_mag[k] = w_sh[k][OUT_W-1] ? MAXV : w_sh[k];
      w_cos[k] = r_v[k][OUT_W-1] ? -w_mag[k] : w_mag[k];
    end
  end
  // Accumulators, sweeps, register loads and the two output pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= '0;
      r_en_d <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= '0;
        r_freq_cur[k] <= '0;
        r_freq_start[k] <= '0;
        r_poff[k] <= '0;
        r_step[k] <= '0;
        r_limit[k] <= '0;
        r_v[k] <= '0;
        r_cos[k] <= '0;
      end
    end else begin
      r_en_d <= {r_en_d[0], i_enable};
      for (int k = 0; k < NCH; k++) begin
        if (i_sync) r_acc[k] <= '0;
        else if (i_enable) r_acc[k] <= r_acc[k] + r_freq_cur[k];
        r_wrap[k] <= w_sweep[k] && w_cross[k];
        if (w_ld_freq[k]) begin
          r_freq_start[k] <= i_load_data;
          r_freq_cur[k] <= i_load_data;
        end else if (w_sweep[k]) begin
          r_freq_cur[k] <= w_cross[k] ? r_freq_start[k] : w_nxt[k][ACC_W-1:0];
        end
        if (w_sel[k] && i_load_sel == 2'd1) r_poff[k] <= i_load_data;
        if (w_sel[k] && i_load_sel == 2'd2) r_step[k] <= i_load_data;
        if (w_sel[k] && i_load_sel == 2'd3) r_limit[k] <= i_load_data;
        r_v[k] <= w_v[k];
        r_cos[k] <= w_cos[k];
      end
    end
  end
  // Pack channel samples onto the output bus
  always_comb begin
    o_cos_out = '0;
    for (int k = 0; k < NCH; k++) o_cos_out[k*OUT_W +: OUT_W] = r_cos[k];
  end
  assign o_out_valid = r_en_d[1];
  assign o_sweep_wrap = r_wrap;
  assign o_io_oeb = '0;
endmodule

// File: tb/tb_dds_multi_sweep.sv
// tb_dds_multi_sweep: directed checks of phase, cosine, sweep, load and reset behaviour
module tb_dds_multi_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sync = 1'b0;
  logic load_en = 1'b0;
  logic load_ch = 1'b0;
  logic [1:0] load_sel = 2'd0;
  logic [23:0] load_data = '0;
  logic [31:0] cos_out;
  logic out_valid;
  logic [1:0] sweep_wrap;
  logic [31:0] io_oeb;
  logic load_en3 = 1'b0;
  logic [1:0] load_ch3 = 2'd0;
  logic [47:0] cos_out3;
  logic out_valid3;
  logic [2:0] sweep_wrap3;
  logic [47:0] io_oeb3;
  int n_chk = 0;
  int n_pass = 0;
  logic [23:0] exp_acc [4] = '{24'h400000, 24'h800000, 24'hC00000, 24'h000000};
  int exp_c0 [4] = '{0, -32767, 0, 32767};
  int exp_c1 [4] = '{32767, 0, -32767, 0};

  dds_multi_sweep #(.NCH(2), .ACC_W(24), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_sync(sync), .i_load_en(load_en),
    .i_load_ch(load_ch), .i_load_sel(load_sel), .i_load_data(load_data),
    .o_cos_out(cos_out), .o_out_valid(out_valid), .o_sweep_wrap(sweep_wrap), .o_io_oeb(io_oeb)
  );

  dds_multi_sweep #(.NCH(3), .ACC_W(24), .OUT_W(16)) dut3 (
    .clk(clk), .rst(rst), .i_enable(1'b0), .i_sync(1'b0), .i_load_en(load_en3),
    .i_load_ch(load_ch3), .i_load_sel(load_sel), .i_load_data(load_data),
    .o_cos_out(cos_out3), .o_out_valid(out_valid3), .o_sweep_wrap(sweep_wrap3), .o_io_oeb(io_oeb3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ld(input int ch, input int sel, input logic [23:0] data);
    load_en = 1'b1;
    load_ch = 1'(ch);
    load_sel = 2'(sel);
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    sync = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic signed [15:0] cs(input int k);
    return $signed(cos_out[k*16 +: 16]);
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_cos", cos_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_wrap", sweep_wrap, 0);
    chk("rst_oeb", io_oeb, 0);
    chk("rst_acc", dut.r_acc[0], 0);
    rst = 1'b0;
    ld(0, 0, 24'h400000);
    enable = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk("s1_acc", dut.r_acc[0], exp_acc[(n-1)%4]);
      if (n == 1) chk("s1_valid_lo", out_valid, 0);
      if (n == 2) chk("s1_valid_hi", out_valid, 1);
      if (n >= 3) chk("s1_cos0", cs(0), exp_c0[(n-3)%4]);
    end
    do_reset();
    ld(0, 0, 24'h400000);
    ld(1, 0, 24'h400000);
    ld(1, 1, 24'hC00000);
    enable = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n >= 3) begin
        chk("s2_cos0", cs(0), exp_c0[(n-3)%4]);
        chk("s2_cos1", cs(1), exp_c1[(n-3)%4]);
      end
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("s2_sync_acc0", dut.r_acc[0], 0);
    chk("s2_sync_acc1", dut.r_acc[1], 0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("s2_acc0", dut.r_acc[0], exp_acc[(j-1)%4]);
      if (j >= 3) begin
        chk("s2_rs_cos0", cs(0), exp_c0[(j-3)%4]);
        chk("s2_rs_cos1", cs(1), exp_c1[(j-3)%4]);
      end
    end
    do_reset();
    ld(0, 0, 24'h000100);
    ld(0, 2, 24'h000100);
    ld(0, 3, 24'h000400);
    chk("s3_f0", dut.r_freq_cur[0], 24'h100);
    enable = 1'b1;
    begin
      logic [23:0] ef [6] = '{24'h200, 24'h300, 24'h400, 24'h100, 24'h200, 24'h300};
      logic [23:0] ea [6] = '{24'h100, 24'h300, 24'h600, 24'hA00, 24'hB00, 24'hD00};
      logic ew [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int n = 0; n < 6; n++) begin
        tick();
        chk("s3_freq", dut.r_freq_cur[0], ef[n]);
        chk("s3_acc", dut.r_acc[0], ea[n]);
        chk("s3_wrap", sweep_wrap, {1'b0, ew[n]});
      end
    end
    enable = 1'b0;
    ld(0, 0, 24'h000400);
    ld(0, 2, 24'hFFFF00);
    ld(0, 3, 24'h000100);
    chk("s3n_f0", dut.r_freq_cur[0], 24'h400);
    enable = 1'b1;
    begin
      logic [23:0] ef [5] = '{24'h300, 24'h200, 24'h100, 24'h400, 24'h300};
      logic ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int n = 0; n < 5; n++) begin
        tick();
        chk("s3n_freq", dut.r_freq_cur[0], ef[n]);
        chk("s3n_wrap", sweep_wrap[0], ew[n]);
      end
    end
    do_reset();
    ld(0, 0, 24'h000100);
    ld(0, 2, 24'h000100);
    ld(0, 3, 24'h000300);
    enable = 1'b1;
    tick();
    tick();
    chk("s4_pre", dut.r_freq_cur[0], 24'h300);
    ld(0, 0, 24'h000050);
    chk("s4_ovr_freq", dut.r_freq_cur[0], 24'h050);
    chk("s4_ovr_wrap", sweep_wrap, 0);
    tick();
    tick();
    chk("s4_f250", dut.r_freq_cur[0], 24'h250);
    tick();
    chk("s4_reload", dut.r_freq_cur[0], 24'h050);
    chk("s4_reload_wrap", sweep_wrap, 2'b01);
    enable = 1'b0;
    load_en3 = 1'b1;
    load_ch3 = 2'd3;
    load_sel = 2'd0;
    load_data = 24'h123456;
    tick();
    chk("s4_ch3_f0", dut3.r_freq_cur[0], 0);
    chk("s4_ch3_f1", dut3.r_freq_cur[1], 0);
    chk("s4_ch3_f2", dut3.r_freq_cur[2], 0);
    load_ch3 = 2'd2;
    tick();
    load_en3 = 1'b0;
    chk("s4_ch2_f2", dut3.r_freq_cur[2], 24'h123456);
    do_reset();
    ld(0, 0, 24'h100000);
    ld(0, 2, 24'h010000);
    ld(0, 3, 24'h800000);
    enable = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("s5_acc_run", dut.r_acc[0], 24'h460000);
    chk("s5_f_run", dut.r_freq_cur[0], 24'h140000);
    enable = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("s5_acc_hold", dut.r_acc[0], 24'h460000);
      chk("s5_f_hold", dut.r_freq_cur[0], 24'h140000);
      chk("s5_valid", out_valid, n == 1);
      if (n >= 2) chk("s5_cos_hold", cs(0), -5856);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_cos", cos_out, 0);
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_wrap", sweep_wrap, 0);
    chk("s5_rst_step", dut.r_step[0], 0);
    enable = 1'b1;
    tick();
    chk("s5_refill0", cs(0), 0);
    tick();
    chk("s5_refill1", cs(0), 32767);
    chk("s5_stopped", dut.r_freq_cur[0], 0);
    do_reset();
    begin
      logic [23:0] po [6] = '{24'h000000, 24'h800000, 24'h400000, 24'hE00000, 24'h600000, 24'hE000FF};
      int ec [6] = '{32767, -32767, 0, 24576, -24576, 24576};
      for (int n = 0; n < 6; n++) begin
        ld(0, 1, po[n]);
        tick();
        tick();
        chk("s6_cos", cs(0), ec[n]);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
